// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, latencies.
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdState_t;

  // Larger of two ints, used for sizing the latency counter.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit product / quotient+remainder for the four md ops.
import md_pkg::*;

module md_calc (
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic signed [32:0] dividendS, divisorS, quotS, remS;
  logic        [31:0] divisorU, quotU, remU;

  // Signed operands are widened by one bit so 0x80000000 / -1 yields +2^31,
  // whose low 32 bits are the required 0x80000000 with a zero remainder.
  // A zero divisor is replaced by 1 only to keep the arithmetic defined; the
  // result is discarded at commit anyway.
  always_comb begin
    prodS     = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prodU     = {32'b0, rs_val} * {32'b0, rt_val};
    dividendS = $signed({rs_val[31], rs_val});
    divisorS  = (rt_val == 32'b0) ? 33'sd1 : $signed({rt_val[31], rt_val});
    quotS     = dividendS / divisorS;
    remS      = dividendS % divisorS;
    divisorU  = (rt_val == 32'b0) ? 32'd1 : rt_val;
    quotU     = rs_val / divisorU;
    remU      = rs_val % divisorU;
    div_zero  = md_op[1] && (rt_val == 32'b0);
    unique case (md_op)
      MD_MULT:  {res_hi, res_lo} = prodS;
      MD_MULTU: {res_hi, res_lo} = prodU;
      MD_DIV:   {res_hi, res_lo} = {remS[31:0], quotS[31:0]};
      default:  {res_hi, res_lo} = {remU, quotU};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency ops with busy handshake.
import md_pkg::*;

module md_unit #(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic        mf_hi,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(maxInt(MULT_CYCLES, DIV_CYCLES) + 1);

  mdState_t          state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       pendHi, pendLo;
  logic              pendZero;
  logic [31:0]       resHi, resLo;
  logic              divZero;

  md_calc calc (
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .res_hi   (resHi),
    .res_lo   (resLo),
    .div_zero (divZero)
  );

  assign busy   = (state == RUN);
  assign md_out = mf_hi ? hi : lo;

  // Issue / countdown / commit; mt writes only when idle and nothing else claims E.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pendHi   <= '0;
      pendLo   <= '0;
      pendZero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            pendHi   <= resHi;
            pendLo   <= resLo;
            pendZero <= divZero;
            cnt      <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state    <= RUN;
          end else if (!start && !flush) begin
            if (mt_hi) hi <= rs_val;
            if (mt_lo) lo <= rs_val;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            if (!pendZero) begin
              hi <= pendHi;
              lo <= pendLo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, start, mt_hi, mt_lo, mf_hi, flush;
  logic [1:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] md_out, hi, lo;

  int total = 0;
  int fails = 0;
  int n;
  int seen;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .mf_hi(mf_hi), .flush(flush), .busy(busy), .md_out(md_out),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; leaves the bench in the first busy cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    step();
    start = 1'b0;
  endtask

  // Count busy cycles until idle, bounded.
  task automatic waitIdle(output int cnt);
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mf_hi = 1'b0;
    flush = 1'b0; md_op = 2'd0; rs_val = '0; rt_val = '0;
    step(); step();
    reset = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    // mult -2 * 3
    issue(2'd0, 32'hFFFFFFFE, 32'd3);
    waitIdle(n);
    chk("mult_busy", n, 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    // multu 0xFFFFFFFF * 2
    issue(2'd1, 32'hFFFFFFFF, 32'd2);
    waitIdle(n);
    chk("multu_busy", n, 5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // div -7 / 2
    issue(2'd2, 32'hFFFFFFF9, 32'd2);
    waitIdle(n);
    chk("div_busy", n, 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // divu 7 / 0: full latency, no commit
    issue(2'd3, 32'd7, 32'd0);
    waitIdle(n);
    chk("divz_busy", n, 10);
    chk("divz_hi", hi, 32'hFFFFFFFF);
    chk("divz_lo", lo, 32'hFFFFFFFD);

    // div overflow corner
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
    waitIdle(n);
    chk("divov_lo", lo, 32'h80000000);
    chk("divov_hi", hi, 32'h0);

    // divu 100 / 7 = 14 r 2
    issue(2'd3, 32'd100, 32'd7);
    waitIdle(n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // mthi then mtlo; md_out shows only registered values
    mt_hi = 1'b1; rs_val = 32'h1234; mf_hi = 1'b1;
    #1 chk("mthi_nobypass", md_out, 32'd2);
    step();
    mt_hi = 1'b0; mt_lo = 1'b1; rs_val = 32'h5678;
    step();
    mt_lo = 1'b0;
    mf_hi = 1'b1; #1 chk("mfhi_out", md_out, 32'h1234);
    mf_hi = 1'b0; #1 chk("mflo_out", md_out, 32'h5678);

    // mult 3*4 with mtlo and a stray start while busy: both ignored
    issue(2'd0, 32'd3, 32'd4);
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 2) begin
        start = 1'b1; md_op = 2'd2; rs_val = 32'hDEAD; rt_val = 32'd1; mt_lo = 1'b1;
      end
      if (n == 3) begin
        start = 1'b0; mt_lo = 1'b0;
      end
      step();
    end
    start = 1'b0; mt_lo = 1'b0;
    chk("busyign_busy", n, 5);
    chk("busyign_lo", lo, 32'd12);
    chk("busyign_hi", hi, 32'd0);

    // start with flush: dropped
    flush = 1'b1;
    issue(2'd0, 32'd5, 32'd5);
    flush = 1'b0;
    chk("flushstart_busy", {31'b0, busy}, 32'd0);
    chk("flushstart_lo", lo, 32'd12);

    // mthi with flush: dropped
    flush = 1'b1; mt_hi = 1'b1; rs_val = 32'd99;
    step();
    flush = 1'b0; mt_hi = 1'b0;
    chk("flushmt_hi", hi, 32'd0);

    // flush during RUN does not abort: multu 6*7
    issue(2'd1, 32'd6, 32'd7);
    n = 0;
    while (busy && n < 50) begin
      n++;
      flush = (n == 2);
      step();
    end
    flush = 1'b0;
    chk("flushrun_busy", n, 5);
    chk("flushrun_lo", lo, 32'd42);

    // start together with mtlo: start wins
    mt_lo = 1'b1;
    issue(2'd1, 32'd2, 32'd3);
    mt_lo = 1'b0;
    waitIdle(n);
    chk("startmt_lo", lo, 32'd6);

    // reset in the 3rd busy cycle of div 20/3
    issue(2'd2, 32'd20, 32'd3);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstrun_busy", {31'b0, busy}, 32'd0);
    chk("rstrun_hi", hi, 32'd0);
    chk("rstrun_lo", lo, 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy) seen++;
      step();
    end
    chk("rstrun_nobusy", seen, 0);
    chk("rstrun_late_lo", lo, 32'd0);
    chk("rstrun_late_hi", hi, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
